// File: rtl/data_mem_responder_pkg.sv
// Shared types, constants and the address-check helper for the data-memory responder.
package data_mem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int WORD_W = 32;
  localparam int CNT_W  = 4;

  // True when a byte address is not word aligned or lies beyond a 2**aw word array.
  function automatic logic addr_err(input logic [31:0] addr, input int unsigned aw);
    return (addr[1:0] != 2'b00) || ((addr >> (aw + 32'd2)) != 32'd0);
  endfunction

endpackage

// File: rtl/data_mem_responder_word_ram.sv
// Single-port synchronous RAM: write enable, read enable, registered read data, no reset.
module word_ram #(
  parameter int DEPTH  = 128,
  parameter int WORD_W = 32,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [AW-1:0]     addr_i,
  input  logic [WORD_W-1:0] wdata_i,
  output logic [WORD_W-1:0] rdata_o
);

  logic [WORD_W-1:0] mem [DEPTH];

  // Write or read one word per edge; the read register holds when not enabled.
  always_ff @(posedge clk_i) begin
    if (we_i) mem[addr_i] <= wdata_i;
    if (re_i) rdata_o <= mem[addr_i];
  end

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle load/store slave with a configurable wait-state count in front of a word RAM.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int DEPTH   = 128,
  parameter int LATENCY = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [31:0]       addr_i,
  input  logic [31:0]       wdata_i,
  output logic              gnt_o,
  output logic              rvalid_o,
  output logic [31:0]       rdata_o,
  output logic              err_o,
  output logic              busy_o
);

  localparam int AW = $clog2(DEPTH);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic              armed_q;
  logic              we_q, err_q;
  logic [AW-1:0]     idx_q;
  logic [WORD_W-1:0] wdata_q;
  logic              zero_q;

  logic              commit;
  logic              in_idle;
  logic              req_err;
  logic              cur_we, cur_err;
  logic [AW-1:0]     cur_idx;
  logic [WORD_W-1:0] cur_wdata;
  logic              ram_we, ram_re;
  logic [WORD_W-1:0] ram_q;

  assign in_idle = (state_q == IDLE);
  assign req_err = addr_err(addr_i, AW);

  // With zero latency the commit edge is the accept edge, so the RAM sees the live request.
  assign cur_we    = in_idle ? we_i              : we_q;
  assign cur_err   = in_idle ? req_err           : err_q;
  assign cur_idx   = in_idle ? addr_i[AW+1:2]    : idx_q;
  assign cur_wdata = in_idle ? wdata_i           : wdata_q;
  assign ram_we    = commit && cur_we  && !cur_err;
  assign ram_re    = commit && !cur_we && !cur_err;

  // State register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state, grant and the commit strobe for the edge entering RESP.
  always_comb begin
    state_d = state_q;
    gnt_o   = 1'b0;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        gnt_o = req_i && armed_q;
        if (gnt_o) begin
          state_d = (LATENCY == 0) ? RESP : WAIT;
          commit  = (LATENCY == 0);
        end
      end
      WAIT: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = RESP;
          commit  = 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Blocks a grant in the cycle reset is released; the first accept comes one edge later.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) armed_q <= 1'b0;
    else        armed_q <= 1'b1;
  end

  // Request latch and wait counter.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
    end else if (gnt_o) begin
      we_q    <= we_i;
      err_q   <= req_err;
      idx_q   <= addr_i[AW+1:2];
      wdata_q <= wdata_i;
      cnt_q   <= CNT_W'(LATENCY);
    end else if (state_q == WAIT) begin
      cnt_q   <= cnt_q - CNT_W'(1);
    end
  end

  // Response flags: err_o for the RESP cycle, zero_q forces rdata_o to 0 after reset or a bad load.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      err_o  <= 1'b0;
      zero_q <= 1'b1;
    end else if (commit) begin
      err_o <= cur_err;
      if (!cur_we) zero_q <= cur_err;
    end else if (state_q == RESP) begin
      err_o <= 1'b0;
    end
  end

  word_ram #(
    .DEPTH  (DEPTH),
    .WORD_W (WORD_W),
    .AW     (AW)
  ) u_ram (
    .clk_i   (clk_i),
    .we_i    (ram_we),
    .re_i    (ram_re),
    .addr_i  (cur_idx),
    .wdata_i (cur_wdata),
    .rdata_o (ram_q)
  );

  assign rdata_o  = zero_q ? '0 : ram_q;
  assign rvalid_o = (state_q == RESP);
  assign busy_o   = (state_q != IDLE);

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: LATENCY=2 and LATENCY=0 instances against a word-array model.
module tb_data_mem_responder;

  logic        clk;
  logic        rst;
  logic        req   [2];
  logic        we    [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic        gnt   [2];
  logic        rvalid[2];
  logic [31:0] rdata [2];
  logic        err   [2];
  logic        busy  [2];

  logic [31:0] mem_m [2][128];
  logic [31:0] rexp  [2];
  int total = 0;
  int bad   = 0;

  data_mem_responder #(.DEPTH(128), .LATENCY(2)) dut0 (
    .clk_i(clk), .rst_i(rst), .req_i(req[0]), .we_i(we[0]), .addr_i(addr[0]),
    .wdata_i(wdata[0]), .gnt_o(gnt[0]), .rvalid_o(rvalid[0]), .rdata_o(rdata[0]),
    .err_o(err[0]), .busy_o(busy[0])
  );

  data_mem_responder #(.DEPTH(128), .LATENCY(0)) dut1 (
    .clk_i(clk), .rst_i(rst), .req_i(req[1]), .we_i(we[1]), .addr_i(addr[1]),
    .wdata_i(wdata[1]), .gnt_o(gnt[1]), .rvalid_o(rvalid[1]), .rdata_o(rdata[1]),
    .err_o(err[1]), .busy_o(busy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One request through the handshake; latency, err and rdata come from the model.
  task automatic access(input int k, input bit w, input logic [31:0] a,
                        input logic [31:0] d, output int waits);
    int lat;
    bit e;
    int idx;
    lat = (k == 0) ? 2 : 0;
    @(negedge clk);
    check_eq($sformatf("idle_busy%0d", k), 32'(busy[k]), 32'd0);
    check_eq($sformatf("idle_rvalid%0d", k), 32'(rvalid[k]), 32'd0);
    check_eq($sformatf("idle_err%0d", k), 32'(err[k]), 32'd0);
    req[k] = 1'b1; we[k] = w; addr[k] = a; wdata[k] = d;
    waits = 0;
    #1;
    while (!gnt[k] && waits < 40) begin
      @(negedge clk); #1;
      waits++;
    end
    check_eq($sformatf("grant%0d", k), 32'(gnt[k]), 32'd1);
    e   = ((a % 4) != 0) || (a >= 32'd512);
    idx = int'((a >> 2) & 32'd127);
    if (!w)      rexp[k] = e ? 32'd0 : mem_m[k][idx];
    else if (!e) mem_m[k][idx] = d;
    @(posedge clk); #1;
    req[k] = 1'b0; we[k] = 1'($urandom); addr[k] = $urandom; wdata[k] = $urandom;
    for (int c = 1; c <= lat + 1; c++) begin
      @(negedge clk);
      if (c <= lat) begin
        check_eq($sformatf("early_rvalid%0d", k), 32'(rvalid[k]), 32'd0);
        check_eq($sformatf("wait_busy%0d", k), 32'(busy[k]), 32'd1);
      end else begin
        check_eq($sformatf("rvalid%0d a=%h", k, a), 32'(rvalid[k]), 32'd1);
        check_eq($sformatf("err%0d a=%h", k, a), 32'(err[k]), 32'(e));
        check_eq($sformatf("rdata%0d a=%h", k, a), rdata[k], rexp[k]);
        check_eq($sformatf("resp_gnt%0d", k), 32'(gnt[k]), 32'd0);
      end
    end
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    int kind;
    a    = 32'($urandom_range(0, 127)) << 2;
    kind = $urandom_range(0, 9);
    if (kind == 0)      a = a | 32'($urandom_range(1, 3));
    else if (kind == 1) a = a | (32'd1 << $urandom_range(9, 31));
    return a;
  endfunction

  initial begin
    int w;
    for (int k = 0; k < 2; k++) begin
      req[k] = 1'b0; we[k] = 1'b0; addr[k] = '0; wdata[k] = '0; rexp[k] = '0;
    end
    rst = 1'b1;
    #1 rst = 1'b0;

    // Reset held with random inputs
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        req[k] = 1'($urandom); we[k] = 1'($urandom); addr[k] = $urandom; wdata[k] = $urandom;
      end
      #1;
      for (int k = 0; k < 2; k++) begin
        check_eq("rst_gnt", 32'(gnt[k]), 32'd0);
        check_eq("rst_rvalid", 32'(rvalid[k]), 32'd0);
        check_eq("rst_err", 32'(err[k]), 32'd0);
        check_eq("rst_busy", 32'(busy[k]), 32'd0);
        check_eq("rst_rdata", rdata[k], 32'd0);
      end
    end
    @(negedge clk);
    req[0] = 1'b0; req[1] = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("post_rst_busy", 32'(busy[0]), 32'd0);
    end

    // Fill both arrays so every later load has a known value
    for (int i = 0; i < 128; i++) access(0, 1'b1, 32'(i) << 2, $urandom, w);
    for (int i = 0; i < 8; i++)   access(1, 1'b1, 32'(i) << 2, $urandom, w);

    // Directed store then load
    access(0, 1'b1, 32'h10, 32'hDEADBEEF, w);
    access(0, 1'b0, 32'h10, 32'h0, w);
    check_eq("b2b_accept_waits", 32'(w), 32'd0);
    check_eq("load_deadbeef", rdata[0], 32'hDEADBEEF);

    // Error cases
    access(0, 1'b0, 32'h13, 32'h0, w);
    access(0, 1'b1, 32'h200, 32'h12345678, w);
    access(0, 1'b0, 32'h0, 32'h0, w);

    // Continuous request: one grant every LATENCY+2 cycles
    @(negedge clk);
    req[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h0;
    rexp[0] = mem_m[0][0];
    for (int i = 0; i < 20; i++) begin
      #1;
      check_eq($sformatf("cont_gnt c%0d", i), 32'(gnt[0]), 32'((i % 4) == 0));
      check_eq($sformatf("cont_rvalid c%0d", i), 32'(rvalid[0]), 32'((i % 4) == 3));
      check_eq($sformatf("cont_busy c%0d", i), 32'(busy[0]), 32'((i % 4) != 0));
      if ((i % 4) == 3) check_eq("cont_rdata", rdata[0], rexp[0]);
      if (i == 19) req[0] = 1'b0;
      @(negedge clk);
    end

    // Reset release with req high: grant only from the next cycle
    rst = 1'b0;
    req[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h10;
    #1 check_eq("in_rst_gnt", 32'(gnt[0]), 32'd0);
    check_eq("in_rst_rdata", rdata[0], 32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1 check_eq("release_gnt", 32'(gnt[0]), 32'd0);
    @(negedge clk);
    #1 check_eq("first_gnt", 32'(gnt[0]), 32'd1);
    rexp[0] = mem_m[0][4];
    @(posedge clk); #1 req[0] = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("post_rel_rvalid", 32'(rvalid[0]), 32'd1);
    check_eq("post_rel_rdata", rdata[0], rexp[0]);
    rexp[1] = 32'd0;

    // Reset during a store before its commit edge
    access(0, 1'b1, 32'h20, 32'h11111111, w);
    @(negedge clk);
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h20; wdata[0] = 32'hCAFEF00D;
    #1 check_eq("abort_gnt", 32'(gnt[0]), 32'd1);
    @(posedge clk); #1 req[0] = 1'b0;
    #2 rst = 1'b0;
    #1 check_eq("abort_busy", 32'(busy[0]), 32'd0);
    check_eq("abort_rvalid", 32'(rvalid[0]), 32'd0);
    rst = 1'b1;
    rexp[0] = 32'd0; rexp[1] = 32'd0;
    access(0, 1'b0, 32'h20, 32'h0, w);
    check_eq("abort_kept_old", rdata[0], 32'h11111111);

    // Randomized traffic
    for (int i = 0; i < 60; i++) access(0, 1'($urandom), rand_addr(), $urandom, w);

    // Zero-latency instance
    access(1, 1'b1, 32'h1C, 32'hA5A5C3C3, w);
    access(1, 1'b0, 32'h1C, 32'h0, w);
    check_eq("lat0_next_accept", 32'(w), 32'd0);
    check_eq("lat0_load", rdata[1], 32'hA5A5C3C3);
    for (int i = 0; i < 20; i++) begin
      logic [31:0] a;
      a = rand_addr() & 32'hFFFF_FE1F;
      access(1, 1'($urandom), a, $urandom, w);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Multi-cycle data-memory responder that answers load/store requests from the CPU datapath over a valid/grant/response handshake. It replaces the zero-latency data memory with a slave that has a configurable wait-state count. This lets the CPU be brought up against realistic memory latency. It checks alignment and range, stores 32-bit words, and returns one response per accepted request.

## Interface
- DEPTH, 128: number of 32-bit words; power of two, 4..4096
- LATENCY, 2: wait cycles between accept and response; 0..15
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous, active-low reset
- req_i  in  1  request valid
- we_i  in  1  1 = store, 0 = load; qualified by req_i
- addr_i  in  32  byte address; qualified by req_i
- wdata_i  in  32  store data; qualified by req_i
- gnt_o  out  1  request accepted this cycle; combinational, req_i && state==IDLE
- rvalid_o  out  1  one-cycle response pulse
- rdata_o  out  32  load data; registered, held between responses
- err_o  out  1  valid with rvalid_o: misaligned or out-of-range access
- busy_o  out  1  state != IDLE

## Operation
- FSM states: IDLE, WAIT, RESP. Reset state is IDLE.
- IDLE:
  - gnt_o = req_i.
  - On accept, latch we_i, word index addr_i[AW+1:2] (AW = log2 DEPTH) and wdata_i.
  - Latch err = (addr_i[1:0] != 0) || (addr_i[31:AW+2] != 0).
  - Load the 4-bit wait counter with LATENCY.
  - Next state is WAIT if LATENCY > 0, else RESP.
- WAIT: decrement the counter each cycle. Move to RESP on the edge where the counter is 1.
- Transition into RESP (a single edge):
  - Store, no error: the array word is written with the latched data; rdata_o is unchanged.
  - Load, no error: rdata_o is loaded from the array word.
  - Load with error: rdata_o is loaded with 0.
  - Store with error: the array is not written; rdata_o is unchanged.
  - err_o is loaded with the latched err.
- RESP: rvalid_o = 1 and gnt_o = 0. Next state is IDLE. err_o returns to 0 when leaving RESP.
- req_i while busy: ignored, no grant, no queuing. The initiator must hold req_i and its qualifiers until gnt_o.
- Reset values: gnt_o 0, rvalid_o 0, rdata_o 0, err_o 0, busy_o 0, state IDLE, counter 0, latched request cleared.
- Memory array has no reset. Contents survive rst_i.

## Timing
- Accept in cycle T gives rvalid_o high in cycle T+LATENCY+1 only.
- Earliest next accept is T+LATENCY+2. Peak throughput is one access per LATENCY+2 cycles.
- Store data is visible to any load accepted after its response.
- Reset mid-operation:
  - Outputs clear asynchronously.
  - A store whose commit edge has not occurred is discarded.
  - A committed store is kept.
- Simultaneous reset release and req_i high: no accept in that cycle. The first accept is possible on the following edge.
- Address arithmetic is unsigned. Upper address bits beyond AW+2 are only error-checked and never wrap into the array.

## Structure
- Shared package holds:
  - state enum (IDLE/WAIT/RESP)
  - WORD_W = 32
  - the counter width constant (4)
  - an address-check function returning the err condition for a given DEPTH
- Sub-module: word_ram, a single-port synchronous RAM with DEPTH and WORD_W parameters. It has a write enable and registered read, with no reset. The FSM, counter, request latch and response registers stay in data_mem_responder.

## Test plan
Defaults for all scenarios: DEPTH=128, LATENCY=2.
- Reset: hold rst_i low with random inputs → gnt_o, rvalid_o, err_o and busy_o are 0 and rdata_o = 0; after release busy_o stays 0 until a request.
- Store then load:
  - Store 0xDEADBEEF to 0x00000010, accepted in cycle 0 → rvalid_o in cycle 3 only, err_o 0.
  - Load 0x00000010 → rvalid_o 3 cycles after its accept, rdata_o 0xDEADBEEF.
- Errors:
  - Load from 0x00000013 → err_o 1, rdata_o 0x00000000.
  - Store 0x12345678 to 0x00000200 → err_o 1.
  - A following load of 0x00000000 returns its prior value.
- Continuous req_i:
  - Hold req_i high for 20 cycles → gnt_o pulses every 4 cycles (0, 4, 8, ...).
  - rvalid_o pulses at 3, 7, 11, ...; busy_o is low only in grant cycles.
- Reset during store:
  - Store 0xCAFEF00D to 0x00000020 over a word holding 0x11111111.
  - Pulse rst_i low in the cycle after accept → after release, a load of 0x00000020 returns 0x11111111.
- LATENCY=0 build: accept in cycle 0 → rvalid_o in cycle 1, next accept in cycle 2, and store-then-load returns the stored word.
